// File: rtl/cl_pkg.sv
// rtl/cl_pkg.sv - shared encodings and defaults for the CameraLink timing pattern generator
package cl_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_CW = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FV_LEAD = 3'd1,
        S_LINE    = 3'd2,
        S_HBLANK  = 3'd3,
        S_VBLANK  = 3'd4
    } state_e;

    localparam logic [1:0] PAT_X   = 2'd0;
    localparam logic [1:0] PAT_Y   = 2'd1;
    localparam logic [1:0] PAT_XY  = 2'd2;
    localparam logic [1:0] PAT_FRM = 2'd3;

endpackage

// File: rtl/cl_timing_pattern_gen.sv
// rtl/cl_timing_pattern_gen.sv - synthetic CameraLink FVAL/LVAL/DVAL/pixel source
module cl_timing_pattern_gen
    import cl_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CW = DEFAULT_CW
) (
    input  logic          data_clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] app_image_h,
    input  logic [CW-1:0] app_image_w,
    input  logic [CW-1:0] app_hblank,
    input  logic [CW-1:0] app_vblank,
    input  logic [CW-1:0] app_fv_lead,
    input  logic [1:0]    pattern_sel,
    output logic          frame_valid,
    output logic          line_valid,
    output logic          data_valid,
    output logic [DW-1:0] dout,
    output logic [CW-1:0] frame_cnt,
    output logic          busy
);

    localparam logic [CW-1:0] ONE = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d, cnt_q, cnt_d;
    logic [CW-1:0] h_q, h_d, w_q, w_d, hb_q, hb_d, vb_q, vb_d, lead_q, lead_d;
    logic [1:0]    pat_q, pat_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic          fv_q, fv_d, lv_q, lv_d, busy_q, busy_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [DW-1:0] px_x, px_y, px_f;
    logic          start_ok, latch;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        h_d      = h_q;
        w_d      = w_q;
        hb_d     = hb_q;
        vb_d     = vb_q;
        lead_d   = lead_q;
        pat_d    = pat_q;
        fcnt_d   = fcnt_q;
        latch    = 1'b0;
        start_ok = en && (app_image_h != '0) && (app_image_w != '0);

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FV_LEAD;
                    latch   = 1'b1;
                end
            end
            S_FV_LEAD: begin
                if (cnt_q == lead_q - ONE) begin
                    state_d = S_LINE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_LINE: begin
                if (x_q == w_q - ONE) begin
                    x_d   = '0;
                    cnt_d = '0;
                    if (y_q == h_q - ONE) begin
                        state_d = S_VBLANK;
                        fcnt_d  = fcnt_q + ONE;
                    end else begin
                        state_d = S_HBLANK;
                    end
                end else begin
                    x_d = x_q + ONE;
                end
            end
            S_HBLANK: begin
                if (cnt_q == hb_q - ONE) begin
                    state_d = S_LINE;
                    y_d     = y_q + ONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_VBLANK: begin
                if (cnt_q == vb_q - ONE) begin
                    // A zero geometry at the boundary parks in idle instead of starting an empty frame
                    if (start_ok) begin
                        state_d = S_FV_LEAD;
                        latch   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (latch) begin
            h_d    = app_image_h;
            w_d    = app_image_w;
            hb_d   = (app_hblank  == '0) ? ONE : app_hblank;
            vb_d   = (app_vblank  == '0) ? ONE : app_vblank;
            lead_d = (app_fv_lead == '0) ? ONE : app_fv_lead;
            pat_d  = pattern_sel;
            cnt_d  = '0;
            x_d    = '0;
            y_d    = '0;
        end

        // Outputs are decoded from next-state so that every output is a flop
        fv_d   = (state_d == S_FV_LEAD) || (state_d == S_LINE) || (state_d == S_HBLANK);
        lv_d   = (state_d == S_LINE);
        busy_d = (state_d != S_IDLE);
        px_x   = DW'(x_d);
        px_y   = DW'(y_d);
        px_f   = DW'(fcnt_d);
        case (pat_d)
            PAT_X:   dout_d = px_x;
            PAT_Y:   dout_d = px_y;
            PAT_XY:  dout_d = px_x + px_y;
            default: dout_d = px_f + px_x;
        endcase
        if (!lv_d) dout_d = '0;
    end

    always_ff @(posedge data_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            h_q     <= '0;
            w_q     <= '0;
            hb_q    <= '0;
            vb_q    <= '0;
            lead_q  <= '0;
            pat_q   <= '0;
            fcnt_q  <= '0;
            fv_q    <= 1'b0;
            lv_q    <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            w_q     <= w_d;
            hb_q    <= hb_d;
            vb_q    <= vb_d;
            lead_q  <= lead_d;
            pat_q   <= pat_d;
            fcnt_q  <= fcnt_d;
            fv_q    <= fv_d;
            lv_q    <= lv_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    assign frame_valid = fv_q;
    assign line_valid  = lv_q;
    assign data_valid  = lv_q;
    assign dout        = dout_q;
    assign frame_cnt   = fcnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_cl_timing_pattern_gen.sv
// tb/tb_cl_timing_pattern_gen.sv - frame-level reference model plus directed and random stimulus
module tb_cl_timing_pattern_gen;

    logic        data_clk = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic [15:0] app_image_h = '0, app_image_w = '0, app_hblank = '0, app_vblank = '0, app_fv_lead = '0;
    logic [1:0]  pattern_sel = '0;
    logic        frame_valid, line_valid, data_valid, busy;
    logic [15:0] dout, frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    cl_timing_pattern_gen #(.DW(16), .CW(16)) dut (
        .data_clk(data_clk), .rst_n(rst_n), .en(en),
        .app_image_h(app_image_h), .app_image_w(app_image_w),
        .app_hblank(app_hblank), .app_vblank(app_vblank), .app_fv_lead(app_fv_lead),
        .pattern_sel(pattern_sel),
        .frame_valid(frame_valid), .line_valid(line_valid), .data_valid(data_valid),
        .dout(dout), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 data_clk = ~data_clk;

    // Reference: when idle (empty queue) a frame is expanded in full from the config seen at that edge
    typedef struct {bit fv; bit lv; bit [15:0] d; bit fall;} item_t;
    item_t       mq[$];
    bit          e_fv = 0, e_lv = 0, e_busy = 0;
    bit [15:0]   e_d = 0, e_fc = 0;

    task automatic build_frame();
        int lead, hb, vb, h, w;
        item_t it;
        lead = (app_fv_lead == 0) ? 1 : int'(app_fv_lead);
        hb   = (app_hblank  == 0) ? 1 : int'(app_hblank);
        vb   = (app_vblank  == 0) ? 1 : int'(app_vblank);
        h    = int'(app_image_h);
        w    = int'(app_image_w);
        for (int i = 0; i < lead; i++) begin it = '{1, 0, 0, 0}; mq.push_back(it); end
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                case (pattern_sel)
                    2'd0:    it.d = 16'(x);
                    2'd1:    it.d = 16'(y);
                    2'd2:    it.d = 16'(x + y);
                    default: it.d = 16'(int'(e_fc) + x);
                endcase
                it.fv = 1; it.lv = 1; it.fall = 0;
                mq.push_back(it);
            end
            if (y < h - 1)
                for (int i = 0; i < hb; i++) begin it = '{1, 0, 0, 0}; mq.push_back(it); end
        end
        for (int i = 0; i < vb; i++) begin it = '{0, 0, 0, (i == 0)}; mq.push_back(it); end
    endtask

    always @(posedge data_clk or negedge rst_n) begin
        item_t it;
        if (!rst_n) begin
            mq.delete();
            e_fv = 0; e_lv = 0; e_d = 0; e_busy = 0; e_fc = 0;
        end else begin
            if (mq.size() == 0 && en && app_image_h != 0 && app_image_w != 0) build_frame();
            if (mq.size() == 0) begin
                e_fv = 0; e_lv = 0; e_d = 0; e_busy = 0;
            end else begin
                it = mq.pop_front();
                e_fv = it.fv; e_lv = it.lv; e_d = it.lv ? it.d : 16'd0; e_busy = 1;
                if (it.fall) e_fc = e_fc + 16'd1;
            end
        end
    end

    always @(negedge data_clk) begin
        vectors++;
        if (frame_valid !== e_fv || line_valid !== e_lv || data_valid !== e_lv ||
            dout !== e_d || busy !== e_busy || frame_cnt !== e_fc) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got fv=%b lv=%b dv=%b dout=%0d busy=%b fc=%0d expected fv=%b lv=%b dv=%b dout=%0d busy=%b fc=%0d",
                     $time, frame_valid, line_valid, data_valid, dout, busy, frame_cnt,
                     e_fv, e_lv, e_lv, e_d, e_busy, e_fc);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg(input int h, input int w, input int hb, input int vb, input int lead, input int pat);
        app_image_h = 16'(h); app_image_w = 16'(w); app_hblank = 16'(hb);
        app_vblank = 16'(vb); app_fv_lead = 16'(lead); pattern_sel = 2'(pat);
    endtask

    logic [15:0] cap[$];
    logic [15:0] expq[$];

    task automatic frame_stats(output int hi, output int lo);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < 500) begin @(negedge data_clk); n++; end
        if (frame_valid !== 1'b1) chk("fv_rise_timeout", frame_valid, 1);
        cap.delete();
        hi = 0;
        while (frame_valid === 1'b1 && hi < 1000) begin
            if (line_valid === 1'b1) cap.push_back(dout);
            hi++;
            @(negedge data_clk);
        end
        lo = 0;
        while (frame_valid === 1'b0 && lo < 60) begin lo++; @(negedge data_clk); end
    endtask

    task automatic chk_cap(input string nm);
        chk({nm, "_len"}, cap.size(), expq.size());
        for (int i = 0; i < expq.size() && i < cap.size(); i++) chk(nm, cap[i], expq[i]);
    endtask

    task automatic wait_lv(input string nm);
        int n;
        n = 0;
        while (line_valid !== 1'b1 && n < 500) begin @(negedge data_clk); n++; end
        if (line_valid !== 1'b1) chk(nm, line_valid, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 500) begin @(negedge data_clk); n++; end
        if (busy !== 1'b0) chk(nm, busy, 0);
    endtask

    initial begin
        int hi, lo, n, m;
        cfg(2, 4, 3, 5, 2, 0);
        repeat (3) @(negedge data_clk);
        chk("reset_fv", frame_valid, 0);
        chk("reset_lv", line_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fc", frame_cnt, 0);
        chk("reset_dout", dout, 0);
        #2 rst_n = 1'b1;
        @(negedge data_clk);
        en = 1'b1;

        // Basic geometry, ramp-x
        frame_stats(hi, lo);
        chk("t1_fv_high", hi, 13);
        chk("t1_fv_low", lo, 5);
        chk("t1_period", hi + lo, 18);
        expq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3};
        chk_cap("t1_dout");
        chk("t1_fc1", frame_cnt, 1);
        frame_stats(hi, lo);
        chk("t1_fc2", frame_cnt, 2);

        // Pattern x+y; takes effect on the frame after the one already latched
        pattern_sel = 2'd2;
        frame_stats(hi, lo);
        frame_stats(hi, lo);
        expq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd1, 16'd2, 16'd3, 16'd4};
        chk_cap("t2_dout");

        // Zero blanking clamps to one cycle
        cfg(2, 4, 0, 0, 0, 0);
        frame_stats(hi, lo);
        frame_stats(hi, lo);
        chk("t3_fv_high", hi, 10);
        chk("t3_fv_low", lo, 1);

        // en dropped during line 0 of a 3x8 frame
        en = 1'b0;
        wait_idle("t4_idle_timeout");
        cfg(3, 8, 2, 2, 1, 0);
        en = 1'b1;
        wait_lv("t4_lv_timeout");
        en = 1'b0;
        n = 0; m = 0;
        while (busy === 1'b1 && m < 300) begin
            if (data_valid === 1'b1) n++;
            m++;
            @(negedge data_clk);
        end
        chk("t4_dv_cycles", n, 24);
        chk("t4_busy", busy, 0);
        n = 0;
        repeat (20) begin if (frame_valid === 1'b1) n++; @(negedge data_clk); end
        chk("t4_no_fv", n, 0);

        // Width change mid-frame
        cfg(2, 4, 1, 2, 1, 0);
        en = 1'b1;
        wait_lv("t5_lv_timeout");
        app_image_w = 16'd6;
        n = 0; m = 0;
        while (frame_valid === 1'b1 && m < 300) begin
            if (line_valid === 1'b1) n++;
            m++;
            @(negedge data_clk);
        end
        chk("t5_old_w_lv", n, 8);
        frame_stats(hi, lo);
        chk("t5_new_w_lv", cap.size(), 12);
        chk("t5_fv_high", hi, 14);

        // Reset at x==2 of a line
        n = 0;
        while (!(line_valid === 1'b1 && dout === 16'd2) && n < 500) begin @(negedge data_clk); n++; end
        chk("t6_x2_reached", dout, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_fv", frame_valid, 0);
        chk("t6_rst_lv", line_valid, 0);
        chk("t6_rst_dv", data_valid, 0);
        chk("t6_rst_dout", dout, 0);
        app_fv_lead = 16'd3;
        @(negedge data_clk);
        #2 rst_n = 1'b1;
        n = 0;
        while (frame_valid !== 1'b1 && n < 100) begin @(negedge data_clk); n++; end
        n = 0;
        while (frame_valid === 1'b1 && line_valid !== 1'b1 && n < 50) begin n++; @(negedge data_clk); end
        chk("t6_lead", n, 3);
        chk("t6_first_lv", line_valid, 1);
        chk("t6_first_dout", dout, 0);

        // Random config, enable and reset activity checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge data_clk);
            n = int'($urandom_range(0, 999));
            if (n < 15)
                cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else if (n < 25)
                en = ($urandom_range(0, 9) != 0);
            else if (n == 999) begin
                #2 rst_n = 1'b0;
                @(negedge data_clk);
                #2 rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
